rx_frame_buffer: RTL
====================

Name: rx_frame_buffer

Overview:
- Upstream stage of the bridge transmit path. Accepts the byte stream from the receive MAC and stores whole frames in a byte FIFO.
- Stores each good frame's length in a separate length FIFO.
- Drops bad, oversized or overflowing frames by rolling back the write pointer.
- The downstream transmit controller reads bytes and lengths through pop strobes and empty flags; it only ever sees complete, committed frames.

Parameters:
- DATA_AW, 11, byte FIFO address width (depth 2^DATA_AW = 2048 bytes)
- LEN_AW, 4, length FIFO address width (depth 16 frames)
- MAX_LEN, 1518, largest accepted frame length in bytes

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_last  in  1  with rx_valid: final byte of the frame
- rx_error  in  1  with rx_last: MAC-reported frame error (FCS/PHY)
- rd_next  in  1  pop one byte from the byte FIFO
- rd_data  out  8  byte at the committed read head
- data_empty  out  1  no committed bytes available
- len_next  in  1  pop one entry from the length FIFO
- frm_len  out  16  length of the head frame; 0 when len_empty
- len_empty  out  1  length FIFO empty
- frame_done  out  1  one-cycle pulse when a frame is committed
- drop_cnt  out  16  saturating count of dropped frames

Behaviour:
- Reset: all pointers 0, state IDLE, rd_data=0, data_empty=1, len_empty=1, frm_len=0, frame_done=0, drop_cnt=0. A frame in progress at reset is lost and not counted.
- Byte FIFO pointers:
  - Pointers are DATA_AW+1 bits: wr_ptr (speculative), wr_cmt (committed), rd_ptr.
  - full = (wr_ptr - rd_ptr) == 2^DATA_AW.
  - data_empty = (rd_ptr == wr_cmt), registered.
- Read side:
  - rd_next while !data_empty increments rd_ptr; rd_data shows mem[rd_ptr], updated one cycle after a pointer change.
  - rd_next while data_empty is ignored.
- Length FIFO:
  - 16-bit entries, pointers LEN_AW+1 bits.
  - len_next while !len_empty pops; frm_len shows the new head (or 0) the next cycle.
  - len_next while empty is ignored.
- State machine (state, byte_cnt[15:0]):
  - IDLE: on rx_valid, write byte at wr_ptr, wr_ptr++, byte_cnt=1, go RECV. If rx_last is also set, apply the end-of-frame rule in the same cycle instead.
  - RECV: on each rx_valid, write byte, wr_ptr++, byte_cnt++. On rx_last, apply the end-of-frame rule, then go IDLE.
  - RECV to DISCARD when a byte arrives while full, or when byte_cnt would exceed MAX_LEN. That byte is not written, and wr_ptr <= wr_cmt immediately.
  - DISCARD: ignore bytes until rx_valid&rx_last, then drop_cnt++ and go IDLE.
- End-of-frame rule:
  - Commit when !rx_error, the last byte fits, byte_cnt ≤ MAX_LEN and the length FIFO is not full.
  - Commit: wr_cmt <= wr_ptr including the last byte, push byte_cnt, pulse frame_done.
  - Otherwise: wr_ptr <= wr_cmt, drop_cnt++ (saturating at 0xFFFF), no push.
- Visibility: data_empty and len_empty deassert the cycle after the commit edge. The length entry and the bytes become visible in the same cycle.
- Simultaneous events:
  - Read pop and write/commit in the same cycle are both honoured.
  - Length pop and push in the same cycle are both honoured; count is unchanged.
  - A commit while a pop empties the FIFO leaves data_empty=0.
- Pointer wrap: modulo 2^(AW+1); frames may straddle the memory end.
- Bytes arriving after a rollback reuse the freed space.

Test Plan:
- Single 64-byte good frame (0x00..0x3F) → frame_done pulse; next cycle len_empty=0, frm_len=64. 64 rd_next pops return 0x00..0x3F in order, then data_empty=1. len_next → frm_len=0, len_empty=1.
- 100-byte frame with rx_error on the last byte → drop_cnt=1, data_empty stays 1, len_empty stays 1. A following 60-byte good frame reads back intact with frm_len=60.
- 1600-byte frame → DISCARD after byte 1518, drop_cnt=1, nothing committed. Next 1518-byte frame commits with frm_len=1518.
- Fill: with no reads, send two 1000-byte frames, then a 100-byte frame → the first two commit. The third overflows at byte 49, is dropped, and drop_cnt=1. Pop 1000 bytes, resend 100 bytes → commits; the wrap-around data is correct.
- Seventeen 60-byte frames without len_next → 16 commit and the 17th is dropped (length FIFO full), drop_cnt=1.
- Assert reset mid-frame after 30 bytes → all outputs at reset values, drop_cnt=0. A subsequent 64-byte frame is stored and read correctly.

Source files
------------

// File: rtl/rx_frame_buffer.sv
// rtl/rx_frame_buffer.sv - receive frame buffer with speculative write and commit/rollback
//
// Stores whole frames from the receive MAC in a byte FIFO and their lengths in a
// length FIFO. Bad, oversized or overflowing frames are removed by rolling the
// speculative write pointer back to the last committed position, so the reader
// only ever sees complete frames.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rx_data/valid/last  incoming byte stream; rx_error qualifies the last byte
//   rd_next             pop one byte; rd_data/data_empty describe the byte head
//   len_next            pop one length; frm_len/len_empty describe the length head
//   frame_done          one-cycle pulse per committed frame
//   drop_cnt            saturating count of dropped frames
module rx_frame_buffer #(
    parameter int DATA_AW = 11,
    parameter int LEN_AW  = 4,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_error,
    input  logic        rd_next,
    output logic [7:0]  rd_data,
    output logic        data_empty,
    input  logic        len_next,
    output logic [15:0] frm_len,
    output logic        len_empty,
    output logic        frame_done,
    output logic [15:0] drop_cnt
);

    localparam int PTR_W  = DATA_AW + 1;
    localparam int LPTR_W = LEN_AW + 1;
    localparam int DEPTH  = 1 << DATA_AW;
    localparam int LDEPTH = 1 << LEN_AW;
    localparam logic [PTR_W-1:0]  DEPTH_P  = PTR_W'(DEPTH);
    localparam logic [LPTR_W-1:0] LDEPTH_P = LPTR_W'(LDEPTH);
    localparam logic [15:0]       MAX_W    = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DISCARD = 2'd2} state_t;

    state_t state_q, state_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [LPTR_W-1:0] len_wr_q, len_wr_d, len_rd_q, len_rd_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              frame_done_q, data_empty_q, len_empty_q;
    logic [7:0]        rd_data_q;
    logic [15:0]       frm_len_q;

    logic [7:0]  mem     [DEPTH];
    logic [15:0] len_mem [LDEPTH];

    logic        full, len_full, too_long;
    logic [15:0] cnt_inc;
    logic        wr_en, commit, drop, rollback, rd_pop, len_pop;

    // Occupancy is measured against the speculative pointer so an in-flight
    // frame cannot overwrite committed bytes that have not been read yet.
    assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign len_full = (len_wr_q - len_rd_q) == LDEPTH_P;
    assign cnt_inc  = (state_q == IDLE) ? 16'd1 : byte_cnt_q + 16'd1;
    assign too_long = cnt_inc > MAX_W;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RECV: begin
                if (rx_valid) begin
                    if (rx_last)               state_d = IDLE;
                    else if (full || too_long) state_d = DISCARD;
                    else                       state_d = RECV;
                end
            end
            DISCARD: begin
                if (rx_valid && rx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: write, commit, drop and rollback strobes
    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        drop     = 1'b0;
        rollback = 1'b0;
        case (state_q)
            IDLE, RECV: begin
                if (rx_valid) begin
                    if (rx_last) begin
                        if (!rx_error && !full && !too_long && !len_full) begin
                            wr_en  = 1'b1;
                            commit = 1'b1;
                        end else begin
                            drop     = 1'b1;
                            rollback = 1'b1;
                        end
                    end else if (full || too_long) begin
                        rollback = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (rx_valid && rx_last) drop = 1'b1;
            end
            default: ;
        endcase
    end

    // Pointer and counter next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        byte_cnt_d = byte_cnt_q;
        if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            byte_cnt_d = cnt_inc;
        end
        if (commit)   wr_cmt_d = wr_ptr_q + PTR_W'(1);
        if (rollback) wr_ptr_d = wr_cmt_q;

        // The pointer compare also blocks the stale cycle right after the last pop.
        rd_pop   = rd_next && !data_empty_q && (rd_ptr_q != wr_cmt_q);
        rd_ptr_d = rd_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        len_pop  = len_next && !len_empty_q && (len_rd_q != len_wr_q);
        len_rd_d = len_pop ? len_rd_q + LPTR_W'(1) : len_rd_q;
        len_wr_d = commit ? len_wr_q + LPTR_W'(1) : len_wr_q;

        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            wr_cmt_q     <= '0;
            rd_ptr_q     <= '0;
            len_wr_q     <= '0;
            len_rd_q     <= '0;
            drop_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            data_empty_q <= 1'b1;
            len_empty_q  <= 1'b1;
            rd_data_q    <= '0;
            frm_len_q    <= '0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_cmt_q     <= wr_cmt_d;
            rd_ptr_q     <= rd_ptr_d;
            len_wr_q     <= len_wr_d;
            len_rd_q     <= len_rd_d;
            drop_cnt_q   <= drop_cnt_d;
            frame_done_q <= commit;
            // Head flags and data are sampled from the settled pointers, so bytes
            // and length of a committed frame appear together one cycle later.
            data_empty_q <= (rd_ptr_q == wr_cmt_q);
            len_empty_q  <= (len_rd_q == len_wr_q);
            rd_data_q    <= mem[rd_ptr_q[DATA_AW-1:0]];
            frm_len_q    <= (len_rd_q == len_wr_q) ? 16'd0 : len_mem[len_rd_q[LEN_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)  mem[wr_ptr_q[DATA_AW-1:0]]    <= rx_data;
        if (commit) len_mem[len_wr_q[LEN_AW-1:0]] <= cnt_inc;
    end

    assign rd_data    = rd_data_q;
    assign data_empty = data_empty_q;
    assign frm_len    = frm_len_q;
    assign len_empty  = len_empty_q;
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
